// File: rtl/vending_pkg.sv
// Shared coin constants and enums for the change dispenser.
package vending_pkg;

  localparam logic [7:0] COIN_05 = 8'd5;
  localparam logic [7:0] COIN_10 = 8'd10;
  localparam logic [7:0] COIN_20 = 8'd20;

  typedef enum logic [1:0] {NONE, C05, C10, C20} coin_t;

  typedef enum logic [1:0] {IDLE, SELECT, EJECT, DONE} state_t;

  function automatic logic [7:0] coin_value(input coin_t c);
    case (c)
      C05:     coin_value = COIN_05;
      C10:     coin_value = COIN_10;
      C20:     coin_value = COIN_20;
      default: coin_value = 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/coin_select.sv
// Greedy coin picker: largest coin that fits the remainder and is in stock.
module coin_select
  import vending_pkg::*;
(
  input  logic [7:0] rem,
  input  logic [7:0] cnt_05,
  input  logic [7:0] cnt_10,
  input  logic [7:0] cnt_20,
  output coin_t      coin
);

  always_comb begin
    coin = NONE;
    if (rem >= COIN_20 && cnt_20 != 8'd0)
      coin = C20;
    else if (rem >= COIN_10 && cnt_10 != 8'd0)
      coin = C10;
    else if (rem >= COIN_05 && cnt_05 != 8'd0)
      coin = C05;
  end

endmodule

// File: rtl/change_dispenser.sv
// Refund FSM: pays out a change amount one coin at a time with ack handshake,
// tracking coin inventory and reporting shortfall or ack timeout.
module change_dispenser
  import vending_pkg::*;
#(
  parameter int INIT_05     = 16,
  parameter int INIT_10     = 16,
  parameter int INIT_20     = 16,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       change_valid,
  input  logic [7:0] change,
  input  logic       eject_ack,
  input  logic       refill,
  output logic       eject_05,
  output logic       eject_10,
  output logic       eject_20,
  output logic       busy,
  output logic       done,
  output logic       short,
  output logic [7:0] shortfall,
  output logic       fault,
  output logic [7:0] cnt_05,
  output logic [7:0] cnt_10,
  output logic [7:0] cnt_20
);

  localparam int TW = (ACK_TIMEOUT < 2) ? 1 : $clog2(ACK_TIMEOUT + 1);

  state_t        state;
  coin_t         sel;
  coin_t         pick;
  logic [7:0]    rem;
  logic [TW-1:0] timer;

  coin_select u_select (
    .rem    (rem),
    .cnt_05 (cnt_05),
    .cnt_10 (cnt_10),
    .cnt_20 (cnt_20),
    .coin   (pick)
  );

  // Timer counts cycles spent waiting in EJECT; expiry abandons the refund.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= IDLE;
      sel       <= NONE;
      rem       <= 8'd0;
      timer     <= '0;
      cnt_05    <= 8'(INIT_05);
      cnt_10    <= 8'(INIT_10);
      cnt_20    <= 8'(INIT_20);
      eject_05  <= 1'b0;
      eject_10  <= 1'b0;
      eject_20  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      short     <= 1'b0;
      shortfall <= 8'd0;
      fault     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (refill) begin
            cnt_05 <= 8'(INIT_05);
            cnt_10 <= 8'(INIT_10);
            cnt_20 <= 8'(INIT_20);
          end
          if (change_valid) begin
            rem   <= change;
            busy  <= 1'b1;
            state <= SELECT;
          end
        end
        SELECT: begin
          timer <= '0;
          if (pick != NONE) begin
            sel      <= pick;
            eject_05 <= (pick == C05);
            eject_10 <= (pick == C10);
            eject_20 <= (pick == C20);
            state    <= EJECT;
          end else begin
            done      <= 1'b1;
            short     <= (rem != 8'd0);
            shortfall <= rem;
            fault     <= 1'b0;
            state     <= DONE;
          end
        end
        EJECT: begin
          if (eject_ack) begin
            rem <= rem - coin_value(sel);
            case (sel)
              C05:     cnt_05 <= cnt_05 - 8'd1;
              C10:     cnt_10 <= cnt_10 - 8'd1;
              C20:     cnt_20 <= cnt_20 - 8'd1;
              default: ;
            endcase
            eject_05 <= 1'b0;
            eject_10 <= 1'b0;
            eject_20 <= 1'b0;
            state    <= SELECT;
          end else if (timer == TW'(ACK_TIMEOUT - 1)) begin
            eject_05  <= 1'b0;
            eject_10  <= 1'b0;
            eject_20  <= 1'b0;
            done      <= 1'b1;
            short     <= 1'b1;
            shortfall <= rem;
            fault     <= 1'b1;
            state     <= DONE;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        DONE: begin
          busy      <= 1'b0;
          short     <= 1'b0;
          shortfall <= 8'd0;
          fault     <= 1'b0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Directed self-checking bench for change_dispenser with default parameters.
module tb_change_dispenser;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       change_valid = 1'b0;
  logic [7:0] change = 8'd0;
  logic       eject_ack = 1'b0;
  logic       refill = 1'b0;
  logic       eject_05, eject_10, eject_20;
  logic       busy, done, short, fault;
  logic [7:0] shortfall, cnt_05, cnt_10, cnt_20;

  int checks = 0;
  int errors = 0;
  int ejected[$];
  int multi = 0;
  int done_pulses = 0;
  int cyc;
  int expq[$];
  int pulses_before;

  change_dispenser dut (
    .clk          (clk),
    .reset        (reset),
    .change_valid (change_valid),
    .change       (change),
    .eject_ack    (eject_ack),
    .refill       (refill),
    .eject_05     (eject_05),
    .eject_10     (eject_10),
    .eject_20     (eject_20),
    .busy         (busy),
    .done         (done),
    .short        (short),
    .shortfall    (shortfall),
    .fault        (fault),
    .cnt_05       (cnt_05),
    .cnt_10       (cnt_10),
    .cnt_20       (cnt_20)
  );

  always #5 clk = ~clk;

  // Record each coin actually handed over (request and ack both high).
  always @(negedge clk) begin
    if (reset) begin
      if (eject_ack && eject_20) ejected.push_back(20);
      if (eject_ack && eject_10) ejected.push_back(10);
      if (eject_ack && eject_05) ejected.push_back(5);
      if ((int'(eject_05) + int'(eject_10) + int'(eject_20)) > 1) multi++;
      if (done) done_pulses++;
    end
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic checkCounts(input string tag, input int c05, input int c10, input int c20);
    checkOutput({tag, "_cnt05"}, int'(cnt_05), c05);
    checkOutput({tag, "_cnt10"}, int'(cnt_10), c10);
    checkOutput({tag, "_cnt20"}, int'(cnt_20), c20);
  endtask

  task automatic checkResult(input string tag, input int s, input int sf, input int f);
    checkOutput({tag, "_short"}, int'(short), s);
    checkOutput({tag, "_shortfall"}, int'(shortfall), sf);
    checkOutput({tag, "_fault"}, int'(fault), f);
  endtask

  task automatic checkSeq(input string tag, input int exp[$]);
    checkOutput({tag, "_len"}, ejected.size(), exp.size());
    for (int i = 0; i < exp.size() && i < ejected.size(); i++)
      checkOutput({tag, "_coin"}, ejected[i], exp[i]);
  endtask

  task automatic checkIdle(input string tag);
    @(negedge clk);
    checkOutput({tag, "_done_clr"}, int'(done), 0);
    checkOutput({tag, "_busy_clr"}, int'(busy), 0);
  endtask

  // Pulse change_valid (optionally with refill) and wait for done; cyc counts
  // negedges after the accepting edge. inject>0 pulses a stray change/refill.
  task automatic applyStimulus(input logic [7:0] amt, input bit with_refill,
                               input int inject, output int n);
    @(negedge clk);
    ejected.delete();
    change       = amt;
    change_valid = 1'b1;
    refill       = with_refill;
    @(negedge clk);
    change_valid = 1'b0;
    refill       = 1'b0;
    change       = 8'd5;
    n = 1;
    while (done !== 1'b1 && n < 300) begin
      if (n == inject) begin
        change_valid = 1'b1;
        refill       = 1'b1;
      end else begin
        change_valid = 1'b0;
        refill       = 1'b0;
      end
      @(negedge clk);
      n++;
    end
    change_valid = 1'b0;
    refill       = 1'b0;
    if (n >= 300) checkOutput("done_wait_expired", 0, 1);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    checkOutput("rst_busy", int'(busy), 0);
    checkOutput("rst_done", int'(done), 0);
    checkOutput("rst_ejects", int'({eject_05, eject_10, eject_20}), 0);
    checkResult("rst", 0, 0, 0);
    checkCounts("rst", 16, 16, 16);
    reset     = 1'b1;
    eject_ack = 1'b1;

    applyStimulus(8'd35, 1'b0, -1, cyc);
    checkOutput("c35_done_cycle", cyc, 8);
    checkResult("c35", 0, 0, 0);
    expq = '{20, 10, 5};
    checkSeq("c35", expq);
    checkCounts("c35", 15, 15, 15);
    checkIdle("c35");

    applyStimulus(8'd0, 1'b0, -1, cyc);
    checkOutput("c0_done_cycle", cyc, 2);
    checkResult("c0", 0, 0, 0);
    checkOutput("c0_ejects", ejected.size(), 0);
    checkIdle("c0");

    applyStimulus(8'd23, 1'b0, -1, cyc);
    checkOutput("c23_done_cycle", cyc, 4);
    checkResult("c23", 1, 3, 0);
    expq = '{20};
    checkSeq("c23", expq);
    checkCounts("c23", 15, 15, 14);
    checkIdle("c23");

    @(negedge clk);
    refill = 1'b1;
    @(negedge clk);
    refill = 1'b0;
    checkCounts("refill", 16, 16, 16);

    applyStimulus(8'd240, 1'b0, -1, cyc);
    checkCounts("c240", 16, 16, 4);
    applyStimulus(8'd60, 1'b0, -1, cyc);
    checkCounts("c60a", 16, 16, 1);

    applyStimulus(8'd60, 1'b0, -1, cyc);
    checkOutput("c60_done_cycle", cyc, 12);
    checkResult("c60", 0, 0, 0);
    expq = '{20, 10, 10, 10, 10};
    checkSeq("c60", expq);
    checkCounts("c60", 16, 12, 0);

    applyStimulus(8'd200, 1'b0, -1, cyc);
    checkResult("drain", 0, 0, 0);
    checkCounts("drain", 0, 0, 0);

    applyStimulus(8'd15, 1'b0, -1, cyc);
    checkOutput("empty_done_cycle", cyc, 2);
    checkResult("empty", 1, 15, 0);
    checkOutput("empty_ejects", ejected.size(), 0);
    checkIdle("empty");

    applyStimulus(8'd35, 1'b1, -1, cyc);
    checkOutput("refill35_done_cycle", cyc, 8);
    checkResult("refill35", 0, 0, 0);
    expq = '{20, 10, 5};
    checkSeq("refill35", expq);
    checkCounts("refill35", 15, 15, 15);

    eject_ack = 1'b0;
    applyStimulus(8'd25, 1'b0, 5, cyc);
    checkOutput("tmo_done_cycle", cyc, 17);
    checkResult("tmo", 1, 25, 1);
    checkOutput("tmo_ejects", ejected.size(), 0);
    checkCounts("tmo", 15, 15, 15);
    checkIdle("tmo");
    repeat (3) @(negedge clk);
    checkOutput("tmo_no_queue_busy", int'(busy), 0);

    @(negedge clk);
    change       = 8'd35;
    change_valid = 1'b1;
    @(negedge clk);
    change_valid = 1'b0;
    @(negedge clk);
    checkOutput("mid_eject20", int'(eject_20), 1);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("mid_rst_ejects", int'({eject_05, eject_10, eject_20}), 0);
    checkOutput("mid_rst_busy", int'(busy), 0);
    checkOutput("mid_rst_done", int'(done), 0);
    checkResult("mid_rst", 0, 0, 0);
    checkCounts("mid_rst", 16, 16, 16);
    reset = 1'b1;
    pulses_before = done_pulses;
    repeat (20) @(negedge clk);
    checkOutput("mid_rst_no_done", done_pulses, pulses_before);
    checkOutput("mid_rst_idle_busy", int'(busy), 0);

    checkOutput("onehot_ejects", multi, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
